// File: rtl/demux_pkg.sv
// Shared sizing helpers and limits for the 1-to-N stream demultiplexer.
// Nothing here holds state; all widths derive from the channel count and beat width.
package demux_pkg;

  localparam int N_MAX  = 64;
  localparam int DW_MIN = 1;

  // Select width for n channels; never narrower than one bit.
  function automatic int sel_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Packed width of one slot's {valid, data} state.
  function automatic int slot_w(input int dw);
    return dw + 1;
  endfunction

endpackage

// File: rtl/demux_1n_stream_if.sv
// Producer-side and per-channel consumer signals of the demux, bundled as one interface.
// in_bcast exists only when DEMUX_BCAST_EN is defined.
interface demux_1n_stream_if
  import demux_pkg::*;
#(
  parameter int N  = 8,
  parameter int DW = 8
);

  localparam int SW = sel_w(N);

  logic [DW-1:0]   in_data;
  logic [SW-1:0]   in_sel;
  logic            in_valid;
  logic            in_ready;
`ifdef DEMUX_BCAST_EN
  logic            in_bcast;
`endif
  logic [N*DW-1:0] out_data;
  logic [N-1:0]    out_valid;
  logic [N-1:0]    out_ready;
  logic            sel_err;

`ifdef DEMUX_BCAST_EN
  modport slave (
    input  in_data, in_sel, in_valid, in_bcast, out_ready,
    output in_ready, out_data, out_valid, sel_err
  );
  modport master (
    output in_data, in_sel, in_valid, in_bcast, out_ready,
    input  in_ready, out_data, out_valid, sel_err
  );
`else
  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_valid, sel_err
  );
  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid, sel_err
  );
`endif

endinterface

// File: rtl/demux_slot.sv
// One-entry output register slot; data appears one cycle after load.
// can_load is high when empty or when the held beat drains this cycle (pass-through replace).
module demux_slot
  import demux_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          can_load
);

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] data;
  } slot_t;

  if ($bits(slot_t) != slot_w(DW)) begin : g_width_err
    $error("demux_slot: slot state width mismatch");
  end

  slot_t st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= '0;
    end else if (load) begin
      st.valid <= 1'b1;
      st.data  <= load_data;
    end else if (st.valid && out_ready) begin
      // Data is left in place after drain; only the valid bit drops.
      st.valid <= 1'b0;
    end
  end

  assign can_load  = !st.valid || out_ready;
  assign out_valid = st.valid;
  assign out_data  = st.data;

endmodule

// File: rtl/demux_1n_stream.sv
// Registered 1-to-N stream demux: 1-cycle latency, one slot per channel.
// A stalled channel only deasserts in_ready for beats selecting it; optional broadcast via DEMUX_BCAST_EN.
module demux_1n_stream
  import demux_pkg::*;
#(
  parameter int N  = 8,
  parameter int DW = 8
) (
  input logic              clk,
  input logic              rst_n,
  demux_1n_stream_if.slave bus
);

  localparam int SW = sel_w(N);

  if (N < 2 || N > N_MAX || DW < DW_MIN) begin : g_param_err
    $error("demux_1n_stream: N must be 2..64 and DW at least 1");
  end

  logic [N-1:0]    can_load;
  logic [N-1:0]    load;
  logic [N-1:0]    slot_valid;
  logic [N*DW-1:0] slot_data;
  logic            bcast;
  logic            sel_hit;
  logic            sel_ready;
  logic            accept;
  logic            sel_err_q;

`ifdef DEMUX_BCAST_EN
  assign bcast = bus.in_bcast;
`else
  assign bcast = 1'b0;
`endif

  // Out-of-range selects match no channel, so sel_ready stays 1 and the beat is swallowed.
  always_comb begin
    sel_ready = 1'b1;
    sel_hit   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (bus.in_sel == SW'(k)) begin
        sel_ready = can_load[k];
        sel_hit   = 1'b1;
      end
    end
  end

  assign bus.in_ready = bcast ? (&can_load) : sel_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    load = '0;
    for (int k = 0; k < N; k++) begin
      load[k] = accept && (bcast || (bus.in_sel == SW'(k)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_q <= 1'b0;
    end else if (accept && !bcast && !sel_hit) begin
      sel_err_q <= 1'b1;
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_slot
    demux_slot #(.DW(DW)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[k]),
      .load_data (bus.in_data),
      .out_ready (bus.out_ready[k]),
      .out_valid (slot_valid[k]),
      .out_data  (slot_data[k*DW +: DW]),
      .can_load  (can_load[k])
    );
  end

  assign bus.out_valid = slot_valid;
  assign bus.out_data  = slot_data;
  assign bus.sel_err   = sel_err_q;

endmodule

// File: tb/tb_demux_1n_stream.sv
// Bench for demux_1n_stream: N=8 instance with per-channel scoreboard, N=6 instance for out-of-range selects.
// Broadcast cases are built only when DEMUX_BCAST_EN is defined.
module tb_demux_1n_stream;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  demux_1n_stream_if #(.N(8), .DW(8)) bus8 ();
  demux_1n_stream_if #(.N(6), .DW(8)) bus6 ();

  demux_1n_stream #(.N(8), .DW(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  demux_1n_stream #(.N(6), .DW(8)) dut6 (.clk(clk), .rst_n(rst_n), .bus(bus6.slave));

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q [8][$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every output handshake on the N=8 instance pops that channel's expected beat.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 8; k++) begin
        if (bus8.out_valid[k] && bus8.out_ready[k]) begin
          if (exp_q[k].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mon_unexpected ch%0d: got 0x%0h expected no beat", k, bus8.out_data[k*8 +: 8]);
          end else begin
            chk($sformatf("mon_data ch%0d", k), 64'(bus8.out_data[k*8 +: 8]), 64'(exp_q[k].pop_front()));
          end
        end
      end
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n)
      (bus8.in_valid && !bus8.in_ready) |=> ($stable(bus8.in_data) && $stable(bus8.in_sel)))
    else begin
      errors++;
      $display("FAIL producer_stable: in_data/in_sel changed while stalled");
    end

  task automatic send(input logic [2:0] sel, input logic [7:0] dat, output int waits);
    bit done;
    @(posedge clk); #1;
    bus8.in_valid = 1'b1;
    bus8.in_sel   = sel;
    bus8.in_data  = dat;
    waits = 0;
    done  = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (bus8.in_ready) begin
        exp_q[sel].push_back(dat);
        done = 1'b1;
      end else begin
        waits++;
        if (waits > 20) begin
          checks++;
          errors++;
          $display("FAIL send_timeout ch%0d: got in_ready=0 for %0d cycles expected accept", sel, waits);
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish within 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst_n          = 1'b0;
    bus8.in_valid  = 1'b0;
    bus8.in_sel    = '0;
    bus8.in_data   = '0;
    bus8.out_ready = 8'hFF;
    bus6.in_valid  = 1'b0;
    bus6.in_sel    = '0;
    bus6.in_data   = '0;
    bus6.out_ready = 6'h3F;
`ifdef DEMUX_BCAST_EN
    bus8.in_bcast  = 1'b0;
    bus6.in_bcast  = 1'b0;
`endif

    #2;
    chk("rst_out_valid8", 64'(bus8.out_valid), 64'h0);
    chk("rst_out_data8", bus8.out_data, 64'h0);
    chk("rst_sel_err8", 64'(bus8.sel_err), 64'h0);
    chk("rst_out_valid6", 64'(bus6.out_valid), 64'h0);
    chk("rst_sel_err6", 64'(bus6.sel_err), 64'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready8", 64'(bus8.in_ready), 64'h1);
    chk("rel_in_ready6", 64'(bus6.in_ready), 64'h1);

    // Single route to channel 3.
    send(3'd3, 8'hA5, w);
    idle();
    @(negedge clk);
    chk("route_valid", 64'(bus8.out_valid), 64'h08);
    chk("route_data", bus8.out_data, 64'h0000_0000_A500_0000);

    // Back-pressure isolation: channel 1 stalled, channel 6 still flows.
    @(posedge clk); #1 bus8.out_ready = 8'hFD;
    send(3'd1, 8'h11, w);
    idle();
    @(posedge clk); #1;
    bus8.in_valid = 1'b1;
    bus8.in_sel   = 3'd1;
    bus8.in_data  = 8'h22;
    @(negedge clk);
    chk("bp_stall", 64'(bus8.in_ready), 64'h0);
    @(negedge clk);
    chk("bp_stall_hold", 64'(bus8.in_ready), 64'h0);
    @(posedge clk); #1 bus8.in_valid = 1'b0;
    @(posedge clk); #1;
    bus8.in_sel  = 3'd6;
    bus8.in_data = 8'h33;
    @(negedge clk);
    chk("bp_other_ready", 64'(bus8.in_ready), 64'h1);
    send(3'd6, 8'h33, w);
    idle();
    @(negedge clk);
    chk("bp_valid", 64'(bus8.out_valid), 64'h42);
    chk("bp_hold_ch1", 64'(bus8.out_data[15:8]), 64'h11);
    chk("bp_data_ch6", 64'(bus8.out_data[55:48]), 64'h33);
    @(posedge clk); #1 bus8.out_ready = 8'hFF;
    send(3'd1, 8'h22, w);
    idle();

    // Streaming: 16 back-to-back beats on channel 0.
    for (int i = 0; i < 16; i++) begin
      send(3'd0, 8'(8'h80 + i), w);
      chk("stream_no_bubble", 64'(w), 64'h0);
      if (i > 0)
        chk("stream_delay", 64'({bus8.out_valid[0], bus8.out_data[7:0]}), 64'({1'b1, 8'(8'h80 + i - 1)}));
    end
    idle();
    @(negedge clk);
    chk("stream_last", 64'({bus8.out_valid[0], bus8.out_data[7:0]}), 64'h18F);

    // Reset mid-traffic with channels 2 and 5 holding beats.
    @(posedge clk); #1 bus8.out_ready = 8'h00;
    send(3'd2, 8'hC2, w);
    send(3'd5, 8'hC5, w);
    idle();
    @(negedge clk);
    chk("mid_filled", 64'(bus8.out_valid), 64'h24);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus8.out_valid), 64'h0);
    chk("mid_rst_data", bus8.out_data, 64'h0);
    chk("mid_rst_sel_err", 64'(bus8.sel_err), 64'h0);
    for (int k = 0; k < 8; k++) exp_q[k].delete();
    @(posedge clk); #1;
    rst_n       = 1'b1;
    bus8.in_sel = 3'd2;
    @(negedge clk);
    chk("mid_rel_ready", 64'(bus8.in_ready), 64'h1);
    @(posedge clk); #1 bus8.out_ready = 8'hFF;

    // Out-of-range select on the N=6 instance.
    @(posedge clk); #1;
    bus6.in_valid = 1'b1;
    bus6.in_sel   = 3'd7;
    bus6.in_data  = 8'hFF;
    @(negedge clk);
    chk("oor_ready", 64'(bus6.in_ready), 64'h1);
    chk("oor_err_before", 64'(bus6.sel_err), 64'h0);
    @(posedge clk); #1 bus6.in_valid = 1'b0;
    @(negedge clk);
    chk("oor_err_set", 64'(bus6.sel_err), 64'h1);
    chk("oor_no_valid", 64'(bus6.out_valid), 64'h0);
    repeat (3) @(negedge clk);
    chk("oor_sticky", 64'(bus6.sel_err), 64'h1);
    @(posedge clk); #1;
    bus6.in_valid = 1'b1;
    bus6.in_sel   = 3'd5;
    bus6.in_data  = 8'h55;
    @(negedge clk);
    chk("n6_ready", 64'(bus6.in_ready), 64'h1);
    @(posedge clk); #1 bus6.in_valid = 1'b0;
    @(negedge clk);
    chk("n6_valid", 64'(bus6.out_valid), 64'h20);
    chk("n6_data", 64'(bus6.out_data[47:40]), 64'h55);

`ifdef DEMUX_BCAST_EN
    // Broadcast waits for every slot, then fills all of them.
    @(posedge clk); #1 bus8.out_ready = 8'hEF;
    send(3'd4, 8'h44, w);
    idle();
    @(posedge clk); #1;
    bus8.in_valid = 1'b1;
    bus8.in_bcast = 1'b1;
    bus8.in_sel   = 3'd0;
    bus8.in_data  = 8'h5A;
    @(negedge clk);
    chk("bcast_stall", 64'(bus8.in_ready), 64'h0);
    @(posedge clk); #1 bus8.out_ready = 8'hFF;
    @(negedge clk);
    chk("bcast_ready", 64'(bus8.in_ready), 64'h1);
    for (int k = 0; k < 8; k++) exp_q[k].push_back(8'h5A);
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    bus8.in_bcast = 1'b0;
    @(negedge clk);
    chk("bcast_valid", 64'(bus8.out_valid), 64'hFF);
    chk("bcast_data", bus8.out_data, {8{8'h5A}});
    chk("bcast_no_err", 64'(bus8.sel_err), 64'h0);
`endif

    // Drain everything and confirm the scoreboard emptied.
    repeat (3) @(negedge clk);
    for (int k = 0; k < 8; k++)
      chk($sformatf("drain_q ch%0d", k), 64'(exp_q[k].size()), 64'h0);
    chk("end_sel_err6", 64'(bus6.sel_err), 64'h1);
    chk("end_sel_err8", 64'(bus8.sel_err), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
